// File: rtl/rs_issue_sched_pkg.sv
// rtl/rs_issue_sched_pkg.sv - shared sizing and boolean constants for the RS issue scheduler
package rs_issue_sched_pkg;
    localparam int   RS_SIZE    = 16;
    localparam int   RS_IDX_LEN = $clog2(RS_SIZE);
    localparam logic TRUE       = 1'b1;
    localparam logic FALSE      = 1'b0;
endpackage

// File: rtl/rs_oldest_pick.sv
// rtl/rs_oldest_pick.sv - combinational issue pick among candidate RS slots
// Build option: RS_AGE_ORDER_EN picks the oldest candidate via the age matrix, else the lowest index.
module rs_oldest_pick #(
    parameter int RS_SIZE = rs_issue_sched_pkg::RS_SIZE,
    parameter int IDX_LEN = $clog2(RS_SIZE)
) (
    input  logic [RS_SIZE-1:0]              cand,
`ifdef RS_AGE_ORDER_EN
    input  logic [RS_SIZE-1:0][RS_SIZE-1:0] age,
`endif
    output logic [IDX_LEN-1:0]              pick,
    output logic                            any
);
`ifdef RS_AGE_ORDER_EN
    logic [RS_SIZE-1:0] older;

    // older[i]: some other candidate predates slot i
    always_comb begin
        older = '0;
        for (int i = 0; i < RS_SIZE; i++)
            for (int j = 0; j < RS_SIZE; j++)
                if (cand[j] && age[j][i]) older[i] = 1'b1;
    end

    always_comb begin
        pick = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--)
            if (cand[i] && !older[i]) pick = IDX_LEN'(i);
    end
`else
    always_comb begin
        pick = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--)
            if (cand[i]) pick = IDX_LEN'(i);
    end
`endif

    assign any = |cand;
endmodule

// File: rtl/rs_issue_sched.sv
// rtl/rs_issue_sched.sv - RS slot occupancy tracker and single-issue scheduler with EX handshake
// Build option: RS_AGE_ORDER_EN enables the age matrix for oldest-ready-first issue.
module rs_issue_sched #(
    parameter int RS_SIZE = rs_issue_sched_pkg::RS_SIZE,
    parameter int IDX_LEN = $clog2(RS_SIZE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena_from_dsp,
    output logic [IDX_LEN-1:0] free_idx_to_rs,
    output logic               full_to_if,
    input  logic [RS_SIZE-1:0] rdy_from_rs,
    output logic               issue_valid_to_ex,
    output logic [IDX_LEN-1:0] issue_idx_to_rs,
    input  logic               issue_ready_from_ex,
    input  logic               rollback_from_rob,
    output logic [IDX_LEN:0]   count_to_dbg
);
    import rs_issue_sched_pkg::*;

    logic [RS_SIZE-1:0] occ_q, occ_d;
    logic               issue_valid_q, issue_valid_d;
    logic [IDX_LEN-1:0] issue_idx_q, issue_idx_d;
    logic [IDX_LEN:0]   count_q, count_d;
    logic [RS_SIZE-1:0] cand;
    logic [IDX_LEN-1:0] pick;
    logic               pick_any;
    logic               alloc, accept, load;

    always_comb begin
        free_idx_to_rs = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--)
            if (!occ_q[i]) free_idx_to_rs = IDX_LEN'(i);
    end

    assign full_to_if = &occ_q;
    assign alloc      = ena_from_dsp && !full_to_if;
    assign accept     = issue_valid_q && issue_ready_from_ex;
    assign load       = !issue_valid_q || issue_ready_from_ex;

    // The held slot must not be re-picked while it is still on offer to EX
    always_comb begin
        cand = rdy_from_rs & occ_q;
        if (issue_valid_q) cand[issue_idx_q] = 1'b0;
    end

`ifdef RS_AGE_ORDER_EN
    logic [RS_SIZE-1:0][RS_SIZE-1:0] age_q, age_d;

    // A new entry is younger than every slot already resident
    always_comb begin
        age_d = age_q;
        if (alloc) begin
            for (int j = 0; j < RS_SIZE; j++) begin
                if (occ_q[j]) begin
                    age_d[j][free_idx_to_rs] = 1'b1;
                    age_d[free_idx_to_rs][j] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) age_q <= '0;
        else     age_q <= age_d;
    end

    rs_oldest_pick #(.RS_SIZE(RS_SIZE), .IDX_LEN(IDX_LEN)) u_pick (
        .cand (cand),
        .age  (age_q),
        .pick (pick),
        .any  (pick_any)
    );
`else
    rs_oldest_pick #(.RS_SIZE(RS_SIZE), .IDX_LEN(IDX_LEN)) u_pick (
        .cand (cand),
        .pick (pick),
        .any  (pick_any)
    );
`endif

    always_comb begin
        occ_d         = occ_q;
        issue_valid_d = issue_valid_q;
        issue_idx_d   = issue_idx_q;
        count_d       = count_q;
        if (rollback_from_rob) begin
            occ_d         = '0;
            issue_valid_d = FALSE;
            issue_idx_d   = '0;
            count_d       = '0;
        end else begin
            if (accept) occ_d[issue_idx_q] = 1'b0;
            if (alloc)  occ_d[free_idx_to_rs] = 1'b1;
            if (load) begin
                issue_valid_d = pick_any;
                if (pick_any) issue_idx_d = pick;
            end
            if (alloc && !accept)      count_d = count_q + 1'b1;
            else if (accept && !alloc) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q         <= '0;
            issue_valid_q <= FALSE;
            issue_idx_q   <= '0;
            count_q       <= '0;
        end else begin
            occ_q         <= occ_d;
            issue_valid_q <= issue_valid_d;
            issue_idx_q   <= issue_idx_d;
            count_q       <= count_d;
        end
    end

    assign issue_valid_to_ex = issue_valid_q;
    assign issue_idx_to_rs   = issue_idx_q;
    assign count_to_dbg      = count_q;
endmodule

// File: tb/tb_rs_issue_sched.sv
// tb/tb_rs_issue_sched.sv - self-checking bench for rs_issue_sched against an allocation-order model
module tb_rs_issue_sched;
    localparam int NS = 16;

    logic          clk, rst, ena, ready, rollback;
    logic [NS-1:0] rdy;
    logic [3:0]    free_idx, issue_idx;
    logic          full, issue_valid;
    logic [4:0]    count;

    int checks = 0;
    int errors = 0;

    rs_issue_sched dut (
        .clk                 (clk),
        .rst                 (rst),
        .ena_from_dsp        (ena),
        .free_idx_to_rs      (free_idx),
        .full_to_if          (full),
        .rdy_from_rs         (rdy),
        .issue_valid_to_ex   (issue_valid),
        .issue_idx_to_rs     (issue_idx),
        .issue_ready_from_ex (ready),
        .rollback_from_rob   (rollback),
        .count_to_dbg        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: occupancy bits plus an allocation sequence number per slot
    bit [NS-1:0] m_occ;
    int unsigned m_seq [NS];
    int unsigned m_ctr;
    bit          m_valid;
    int          m_idx;
    int          m_count;

    function automatic int model_free(input bit [NS-1:0] o);
        for (int i = 0; i < NS; i++)
            if (!o[i]) return i;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin : model_upd
        int          f, best;
        bit          acc, alc;
        bit [NS-1:0] occ_n;
        if (rst) begin
            m_occ <= '0; m_valid <= 1'b0; m_idx <= 0; m_count <= 0; m_ctr <= 0;
        end else if (rollback) begin
            m_occ <= '0; m_valid <= 1'b0; m_idx <= 0; m_count <= 0;
        end else begin
            f     = model_free(m_occ);
            alc   = ena && (m_occ != '1);
            acc   = m_valid && ready;
            best  = -1;
            for (int i = 0; i < NS; i++) begin
                if (rdy[i] && m_occ[i] && !(m_valid && m_idx == i)) begin
`ifdef RS_AGE_ORDER_EN
                    if (best < 0 || m_seq[i] < m_seq[best]) best = i;
`else
                    if (best < 0) best = i;
`endif
                end
            end
            if (!m_valid || ready) begin
                m_valid <= (best >= 0);
                if (best >= 0) m_idx <= best;
            end
            occ_n = m_occ;
            if (acc) occ_n[m_idx] = 1'b0;
            if (alc) begin
                occ_n[f] = 1'b1;
                m_seq[f] <= m_ctr;
                m_ctr    <= m_ctr + 1;
            end
            m_occ   <= occ_n;
            m_count <= m_count + int'(alc) - int'(acc);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmp_full",  32'(full),        32'(m_occ == '1));
        chk("cmp_free",  32'(free_idx),    32'(model_free(m_occ)));
        chk("cmp_valid", 32'(issue_valid), 32'(m_valid));
        chk("cmp_idx",   32'(issue_idx),   32'(m_idx));
        chk("cmp_count", 32'(count),       32'(m_count));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        rollback = 1'b1;
        step();
        rollback = 1'b0;
        rdy = '0;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; rdy = '0; ready = 1'b0; rollback = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        chk("reset_full", 32'(full), 0);
        chk("reset_free", 32'(free_idx), 0);
        chk("reset_valid", 32'(issue_valid), 0);
        chk("reset_count", 32'(count), 0);

        // slots 0,1,2 with only 1 and 2 ready; EX stalls
        rdy = 16'h0006; ena = 1'b1;
        step(); step(); step();
        ena = 1'b0;
        chk("first_idx", 32'(issue_idx), 1);
        chk("first_valid", 32'(issue_valid), 1);
        chk("first_count", 32'(count), 3);
        repeat (3) begin
            step();
            chk("hold_idx", 32'(issue_idx), 1);
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("next_idx", 32'(issue_idx), 2);
        chk("next_count", 32'(count), 2);
        flush();
        chk("rb_count", 32'(count), 0);

        // fill every slot, then one more allocate
        ena = 1'b1;
        repeat (NS) step();
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 16);
        step();
        ena = 1'b0;
        chk("over_count", 32'(count), 16);
        chk("over_free", 32'(free_idx), 0);
        rdy = '1;
        step();
        chk("full_issue_idx", 32'(issue_idx), 0);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("unfull", 32'(full), 0);
        chk("unfull_count", 32'(count), 15);
        chk("unfull_free", 32'(free_idx), 0);
        chk("b2b_idx", 32'(issue_idx), 1);
        flush();

        // age order: free slot 3 while 5 stays resident, then reuse 3
        ena = 1'b1;
        repeat (6) step();
        ena = 1'b0;
        rdy = 16'h0008; ready = 1'b1;
        step(); step();
        ready = 1'b0; rdy = '0;
        chk("age_free", 32'(free_idx), 3);
        chk("age_count5", 32'(count), 5);
        ena = 1'b1;
        step();
        ena = 1'b0;
        rdy = 16'h0028;
        step();
`ifdef RS_AGE_ORDER_EN
        chk("age_first", 32'(issue_idx), 5);
`else
        chk("age_first", 32'(issue_idx), 3);
`endif
        ready = 1'b1;
        step();
        ready = 1'b0;
`ifdef RS_AGE_ORDER_EN
        chk("age_second", 32'(issue_idx), 3);
`else
        chk("age_second", 32'(issue_idx), 5);
`endif
        chk("age_count", 32'(count), 5);
        flush();

        // alloc and accept together, then alloc+accept+rollback together
        rdy = 16'h0001; ena = 1'b1;
        step();
        ena = 1'b0;
        step();
        chk("aa_valid0", 32'(issue_valid), 1);
        ena = 1'b1; ready = 1'b1;
        step();
        ena = 1'b0; ready = 1'b0;
        chk("aa_count", 32'(count), 1);
        chk("aa_free", 32'(free_idx), 0);
        rdy = 16'h0003;
        step();
        chk("aa_idx1", 32'(issue_idx), 1);
        ena = 1'b1; ready = 1'b1; rollback = 1'b1;
        step();
        ena = 1'b0; ready = 1'b0; rollback = 1'b0; rdy = '0;
        chk("aar_count", 32'(count), 0);
        chk("aar_valid", 32'(issue_valid), 0);
        chk("aar_free", 32'(free_idx), 0);

        // asynchronous reset between edges
        rdy = 16'h0001; ena = 1'b1;
        step();
        ena = 1'b0;
        step();
        chk("ar_pre_valid", 32'(issue_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 32'(issue_valid), 0);
        chk("ar_count", 32'(count), 0);
        step();
        rst = 1'b0; rdy = '0;
        step();
        chk("ar_after_free", 32'(free_idx), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
